// File: rtl/axis_traffic_gen_if.sv
// AXI4-Stream bundle for the traffic generator.
// Master drives data/valid/last, slave returns ready.
interface axis_traffic_gen_if #(
  parameter int DW = 512
);
  logic [DW-1:0] axis_tdata;
  logic          axis_tvalid;
  logic          axis_tready;
  logic          axis_tlast;

  modport master (
    output axis_tdata,
    output axis_tvalid,
    output axis_tlast,
    input  axis_tready
  );

  modport slave (
    input  axis_tdata,
    input  axis_tvalid,
    input  axis_tlast,
    output axis_tready
  );
endinterface

// File: rtl/axis_traffic_gen.sv
// AXI4-Stream loopback traffic source: fixed-length packets,
// lane i carries seq+i, optional idle gaps, finite or free-running.
module axis_traffic_gen #(
  parameter int DW    = 512,
  parameter int LEN_W = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              stop,
  input  logic [LEN_W-1:0]  packet_len,
  input  logic [LEN_W-1:0]  gap_cycles,
  input  logic [31:0]       packet_count,
  axis_traffic_gen_if.master axis,
  output logic              busy,
  output logic              done,
  output logic [31:0]       packets_sent
);

  localparam int LANES = DW / 32;
  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [31:0]      seq_q, seq_d;
  logic [31:0]      sent_q, sent_d;
  logic [31:0]      cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] gcfg_q, gcfg_d;
  logic [LEN_W-1:0] beat_q, beat_d;
  logic [LEN_W-1:0] gap_q, gap_d;
  logic             stop_q, stop_d;
  logic             done_q, done_d;

  logic             valid;
  logic             last;
  logic             hs;
  logic             stop_now;
  logic             run_end;
  logic [DW-1:0]    pattern;

  assign valid    = (state_q == SEND);
  assign last     = valid && (beat_q == len_q - ONE);
  assign hs       = valid && axis.axis_tready;
  assign stop_now = stop_q || stop;
  assign run_end  = ((cnt_q != 32'd0) && (sent_q + 32'd1 == cnt_q))
                  || stop_now;

  always_comb begin
    pattern = '0;
    for (int i = 0; i < LANES; i++) begin
      pattern[32*i +: 32] = seq_q + 32'(i);
    end
  end

  // Outputs are pure functions of flops, so they hold across stalls.
  assign axis.axis_tvalid = valid;
  assign axis.axis_tlast  = last;
  assign axis.axis_tdata  = valid ? pattern : '0;

  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign packets_sent = sent_q;

  always_comb begin
    state_d = state_q;
    seq_d   = seq_q;
    sent_d  = sent_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    gcfg_d  = gcfg_q;
    beat_d  = beat_q;
    gap_d   = gap_q;
    stop_d  = stop_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d = SEND;
          len_d   = (packet_len == '0) ? ONE : packet_len;
          gcfg_d  = gap_cycles;
          cnt_d   = packet_count;
          seq_d   = '0;
          sent_d  = '0;
          beat_d  = '0;
          gap_d   = '0;
        end
      end
      SEND: begin
        if (stop) stop_d = 1'b1;
        if (hs) begin
          seq_d = seq_q + 32'd1;
          if (last) begin
            beat_d = '0;
            sent_d = sent_q + 32'd1;
            if (run_end) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else if (gcfg_q != '0) begin
              state_d = GAP;
              gap_d   = '0;
            end
          end else begin
            beat_d = beat_q + ONE;
          end
        end
      end
      GAP: begin
        if (stop_now) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (gap_q == gcfg_q - ONE) begin
          state_d = SEND;
        end else begin
          gap_d = gap_q + ONE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d == IDLE) stop_d = 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      seq_q   <= '0;
      sent_q  <= '0;
      cnt_q   <= '0;
      len_q   <= ONE;
      gcfg_q  <= '0;
      beat_q  <= '0;
      gap_q   <= '0;
      stop_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      sent_q  <= sent_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      gcfg_q  <= gcfg_d;
      beat_q  <= beat_d;
      gap_q   <= gap_d;
      stop_q  <= stop_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_axis_traffic_gen.sv
// Bench for axis_traffic_gen: directed scenarios plus random runs
// checked beat-by-beat against a packet-level reference model.
module tb_axis_traffic_gen;

  localparam int DW    = 512;
  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic [LEN_W-1:0] packet_len = '0;
  logic [LEN_W-1:0] gap_cycles = '0;
  logic [31:0]      packet_count = '0;
  logic             busy;
  logic             done;
  logic [31:0]      packets_sent;
  logic [15:0]      rpat = 16'hFFFF;

  int checks = 0;
  int errors = 0;

  axis_traffic_gen_if #(.DW(DW)) axis ();

  axis_traffic_gen #(.DW(DW), .LEN_W(LEN_W)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .start        (start),
    .stop         (stop),
    .packet_len   (packet_len),
    .gap_cycles   (gap_cycles),
    .packet_count (packet_count),
    .axis         (axis),
    .busy         (busy),
    .done         (done),
    .packets_sent (packets_sent)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pat(input logic [31:0] s);
    logic [DW-1:0] v;
    v = '0;
    for (int i = 0; i < DW / 32; i++) v[32*i +: 32] = s + 32'(i);
    return v;
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Run one configuration; the model tracks beat index, packets and gaps.
  task automatic do_run(input int len, input int gap, input int cnt,
                        input int pct, input int stop_beat,
                        input string nm);
    int L, total, idx, pkts, gap_left;
    bit fin, stopped, exp_v, rdy, lst;
    L = (len == 0) ? 1 : len;
    total = (stop_beat >= 0) ? (stop_beat / L + 1) : cnt;
    if (stop_beat >= 0 && cnt != 0 && cnt < total) total = cnt;
    @(negedge clk);
    packet_len   = LEN_W'(len);
    gap_cycles   = LEN_W'(gap);
    packet_count = 32'(cnt);
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    idx = 0; pkts = 0; gap_left = 0;
    fin = 0; stopped = 0; exp_v = 1;
    for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
      check({nm, " busy"}, DW'(busy), DW'(1));
      check({nm, " sent"}, DW'(packets_sent), DW'(pkts));
      check({nm, " tvalid"}, DW'(axis.axis_tvalid), DW'(exp_v));
      if (exp_v) begin
        lst = ((idx % L) == L - 1);
        check({nm, " tdata"}, axis.axis_tdata, pat(32'(idx)));
        check({nm, " tlast"}, DW'(axis.axis_tlast), DW'(lst));
      end
      if (pct < 0) rdy = (cyc < 16) ? rpat[cyc] : 1'b1;
      else rdy = ($urandom_range(99) < pct);
      axis.axis_tready = rdy;
      if (exp_v && !stopped && stop_beat >= 0 && idx == stop_beat) begin
        stop = 1'b1;
        stopped = 1;
      end
      if (cyc == 3) begin
        start        = 1'b1;
        packet_len   = LEN_W'($urandom);
        gap_cycles   = LEN_W'($urandom);
        packet_count = $urandom;
      end
      if (exp_v) begin
        if (rdy) begin
          lst = ((idx % L) == L - 1);
          idx++;
          if (lst) begin
            pkts++;
            if (pkts == total) fin = 1;
            else gap_left = gap;
          end
        end
      end else begin
        gap_left--;
      end
      exp_v = (gap_left == 0);
      @(negedge clk);
      stop  = 1'b0;
      start = 1'b0;
    end
    check({nm, " timeout"}, DW'(fin), DW'(1));
    check({nm, " done"}, DW'(done), DW'(1));
    check({nm, " busy_end"}, DW'(busy), DW'(0));
    check({nm, " tvalid_end"}, DW'(axis.axis_tvalid), DW'(0));
    check({nm, " sent_end"}, DW'(packets_sent), DW'(total));
    axis.axis_tready = 1'b1;
    @(negedge clk);
    check({nm, " done_once"}, DW'(done), DW'(0));
    check({nm, " tvalid_idle"}, DW'(axis.axis_tvalid), DW'(0));
    check({nm, " sent_hold"}, DW'(packets_sent), DW'(total));
  endtask

  initial begin
    axis.axis_tready = 1'b1;
    #12;
    check("rst tvalid", DW'(axis.axis_tvalid), DW'(0));
    check("rst tlast", DW'(axis.axis_tlast), DW'(0));
    check("rst tdata", axis.axis_tdata, '0);
    check("rst busy", DW'(busy), DW'(0));
    check("rst done", DW'(done), DW'(0));
    check("rst sent", DW'(packets_sent), DW'(0));
    @(negedge clk);
    resetn = 1'b1;

    do_run(4, 0, 3, 100, -1, "burst");
    do_run(2, 5, 2, 100, -1, "gap");
    rpat = 16'hFFE9;
    do_run(3, 0, 1, -1, -1, "bp");
    rpat = 16'hFFFF;
    do_run(8, 0, 0, 100, 2, "stop");
    do_run(0, 1, 3, 100, -1, "len0");

    @(negedge clk);
    start = 1'b1; stop = 1'b1;
    packet_len = 16'd4; packet_count = 32'd1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("ss busy", DW'(busy), DW'(0));
      check("ss tvalid", DW'(axis.axis_tvalid), DW'(0));
      check("ss done", DW'(done), DW'(0));
      @(negedge clk);
    end

    axis.axis_tready = 1'b0;
    packet_len = 16'd4; gap_cycles = 16'd0; packet_count = 32'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("wrap v0", DW'(axis.axis_tvalid), DW'(1));
    check("wrap d0", axis.axis_tdata, pat(32'd0));
    force dut.seq_q = 32'hFFFF_FFFE;
    @(posedge clk);
    #1 release dut.seq_q;
    @(negedge clk);
    check("wrap d1", axis.axis_tdata, pat(32'hFFFF_FFFE));
    check("wrap lane2", DW'(axis.axis_tdata[95:64]), DW'(0));
    axis.axis_tready = 1'b1;
    @(negedge clk);
    check("wrap d2", axis.axis_tdata, pat(32'hFFFF_FFFF));
    @(negedge clk);
    check("wrap lane0", DW'(axis.axis_tdata[31:0]), DW'(0));
    @(negedge clk);
    check("wrap last", DW'(axis.axis_tlast), DW'(1));
    check("wrap d4", axis.axis_tdata, pat(32'd1));
    @(negedge clk);
    check("wrap done", DW'(done), DW'(1));
    check("wrap sent", DW'(packets_sent), DW'(1));

    @(negedge clk);
    packet_len = 16'd1; gap_cycles = 16'd0; packet_count = 32'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    axis.axis_tready = 1'b0;
    check("rr sent", DW'(packets_sent), DW'(3));
    check("rr tvalid", DW'(axis.axis_tvalid), DW'(1));
    #2 resetn = 1'b0;
    #1;
    check("rr async tvalid", DW'(axis.axis_tvalid), DW'(0));
    check("rr async busy", DW'(busy), DW'(0));
    check("rr async sent", DW'(packets_sent), DW'(0));
    check("rr async tdata", axis.axis_tdata, '0);
    @(negedge clk);
    resetn = 1'b1;
    axis.axis_tready = 1'b1;
    do_run(3, 1, 2, 100, -1, "postrst");

    for (int r = 0; r < 8; r++) begin
      do_run($urandom_range(6), $urandom_range(4), $urandom_range(4, 1),
             $urandom_range(100, 50),
             ($urandom_range(3) == 0) ? $urandom_range(10) : -1, "rand");
    end
    do_run(5, 2, 0, 70, $urandom_range(20), "randstop");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
